// File: rtl/interrupt_tlx_mc.sv
// Multi-channel TLX interrupt requester: per-channel FSMs, round-robin command issue, tag-routed responses.
// Optional macro INTERRUPT_TLX_EXP_BACKOFF_EN scales the backoff time by a per-channel retry count.
module interrupt_tlx_mc #(
  parameter int NCH  = 4,
  parameter int CTXW = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [11:0]           cfg_actag_base,
  input  logic [19:0]           cfg_pasid_base,
  input  logic [19:0]           cfg_pasid_mask,
  input  logic [3:0]            backoff_limit,
  input  logic                  interrupt_enable,
  input  logic [NCH-1:0]        interrupt_req,
  input  logic [NCH*64-1:0]     interrupt_src,
  input  logic [NCH*CTXW-1:0]   interrupt_ctx,
  output logic [NCH-1:0]        interrupt_ack,
  output logic [NCH-1:0]        interrupt_err,
  output logic                  tlx_cmd_valid,
  output logic [7:0]            tlx_cmd_opcode,
  output logic [67:0]           tlx_cmd_obj,
  output logic [15:0]           tlx_cmd_afutag,
  output logic [19:0]           tlx_cmd_pasid,
  output logic [11:0]           tlx_cmd_actag,
  input  logic                  tlx_rsp_valid,
  input  logic [15:0]           tlx_rsp_afutag,
  input  logic [7:0]            tlx_rsp_opcode,
  input  logic [3:0]            tlx_rsp_code
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ      = 3'd1;
  localparam logic [2:0] ST_WAIT_RSP = 3'd2;
  localparam logic [2:0] ST_PENDING  = 3'd3;
  localparam logic [2:0] ST_BACKOFF  = 3'd4;
  localparam logic [2:0] ST_ACK      = 3'd5;

  localparam logic [7:0] OP_INTRP_REQ  = 8'h58;
  localparam logic [7:0] OP_INTRP_RESP = 8'h0C;
  localparam logic [7:0] OP_INTRP_RDY  = 8'h1A;

  logic [NCH-1:0]  req_vec;
  logic [NCH-1:0]  grant_vec;
  logic [NCH-1:0]  rsp_hit;
  logic            grant_any;
  logic [CHW-1:0]  grant_idx;
  logic [CHW-1:0]  ptr_reg;
  logic            tag_ok;
  int              arb_idx;
  logic [63:0]     src_sel [NCH];
  logic [CTXW-1:0] ctx_sel [NCH];

  // Tag prefix check shared by all channels; the low CHW bits select the channel.
  assign tag_ok = tlx_rsp_valid && (tlx_rsp_afutag[15:14] == 2'b11) &&
                  (tlx_rsp_afutag[13:CHW] == '0);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      arb_idx = (int'(ptr_reg) + k) % NCH;
      if (!grant_any && interrupt_enable && req_vec[arb_idx]) begin
        grant_any = 1'b1;
        grant_idx = CHW'(arb_idx);
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [2:0]      state_reg;
    logic [2:0]      state_next;
    logic [63:0]     src_reg;
    logic [CTXW-1:0] ctx_reg;
    logic [23:0]     cnt_reg;
    logic [23:0]     t_val;
    logic            ack_reg;
    logic            err_reg;
    logic            fail_next;

`ifdef INTERRUPT_TLX_EXP_BACKOFF_EN
    logic [2:0]  rty_reg;
    logic [2:0]  rty_inc;
    logic [31:0] t_wide;
    assign rty_inc = (rty_reg == 3'd7) ? 3'd7 : rty_reg + 3'd1;
    assign t_wide  = (32'd20 << backoff_limit) << rty_inc;
    assign t_val   = (t_wide > 32'h00FF_FFFF) ? 24'hFF_FFFF : t_wide[23:0];
`else
    assign t_val = 24'd20 << backoff_limit;
`endif

    assign req_vec[gi]       = (state_reg == ST_REQ);
    assign grant_vec[gi]     = grant_any && (grant_idx == CHW'(gi));
    assign rsp_hit[gi]       = tag_ok && (tlx_rsp_afutag[CHW-1:0] == CHW'(gi));
    assign src_sel[gi]       = src_reg;
    assign ctx_sel[gi]       = ctx_reg;
    assign interrupt_ack[gi] = ack_reg;
    assign interrupt_err[gi] = err_reg;

    always_comb begin
      state_next = state_reg;
      fail_next  = 1'b0;
      case (state_reg)
        ST_IDLE:     if (interrupt_req[gi]) state_next = ST_REQ;
        ST_REQ:      if (grant_vec[gi]) state_next = ST_WAIT_RSP;
        ST_WAIT_RSP: begin
          if (rsp_hit[gi] && tlx_rsp_opcode == OP_INTRP_RESP) begin
            case (tlx_rsp_code)
              4'h0:                      state_next = ST_ACK;
              4'h2:                      state_next = ST_BACKOFF;
              4'h4:                      state_next = ST_PENDING;
              4'h8, 4'h9, 4'hB, 4'hE: begin
                state_next = ST_ACK;
                fail_next  = 1'b1;
              end
              default:                   state_next = state_reg;
            endcase
          end
        end
        ST_PENDING: begin
          if (rsp_hit[gi] && tlx_rsp_opcode == OP_INTRP_RDY) begin
            if (tlx_rsp_code == 4'h0)      state_next = ST_REQ;
            else if (tlx_rsp_code == 4'h2) state_next = ST_BACKOFF;
          end
        end
        ST_BACKOFF:  if (cnt_reg == 24'd0) state_next = ST_REQ;
        ST_ACK:      if (!interrupt_req[gi]) state_next = ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= ST_IDLE;
        src_reg   <= '0;
        ctx_reg   <= '0;
        cnt_reg   <= '0;
        ack_reg   <= 1'b0;
        err_reg   <= 1'b0;
`ifdef INTERRUPT_TLX_EXP_BACKOFF_EN
        rty_reg   <= '0;
`endif
      end else begin
        state_reg <= state_next;
        if (state_reg == ST_IDLE && state_next == ST_REQ) begin
          src_reg <= interrupt_src[64*gi +: 64];
          ctx_reg <= interrupt_ctx[CTXW*gi +: CTXW];
        end
        // Counter holds T-1 on entry so the channel spends exactly T cycles here.
        if (state_next == ST_BACKOFF && state_reg != ST_BACKOFF) cnt_reg <= t_val - 24'd1;
        else if (state_reg == ST_BACKOFF && cnt_reg != 24'd0)    cnt_reg <= cnt_reg - 24'd1;
        ack_reg <= (state_next == ST_ACK);
        if (state_next != ST_ACK)        err_reg <= 1'b0;
        else if (state_reg != ST_ACK)    err_reg <= fail_next;
`ifdef INTERRUPT_TLX_EXP_BACKOFF_EN
        if (state_next == ST_BACKOFF && state_reg != ST_BACKOFF) rty_reg <= rty_inc;
        else if (state_next == ST_ACK || state_next == ST_IDLE)  rty_reg <= '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg        <= '0;
      tlx_cmd_valid  <= 1'b0;
      tlx_cmd_opcode <= '0;
      tlx_cmd_obj    <= '0;
      tlx_cmd_afutag <= '0;
      tlx_cmd_pasid  <= '0;
      tlx_cmd_actag  <= '0;
    end else begin
      tlx_cmd_valid <= grant_any;
      if (grant_any) begin
        ptr_reg        <= (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        tlx_cmd_opcode <= OP_INTRP_REQ;
        tlx_cmd_obj    <= {4'h0, src_sel[grant_idx]};
        tlx_cmd_afutag <= {2'b11, {(14 - CHW){1'b0}}, grant_idx};
        tlx_cmd_pasid  <= (cfg_pasid_base & cfg_pasid_mask) |
                          (20'(ctx_sel[grant_idx]) & ~cfg_pasid_mask);
        tlx_cmd_actag  <= cfg_actag_base + 12'(ctx_sel[grant_idx]);
      end
    end
  end
endmodule
